// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and defaults for the round-robin 4:1 mux arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rr_mux_arbiter_pkg;

    // Two-state controller: channel free, or channel owned by r_sel.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int HOLD_MAX_DEF = 8;
    localparam int CNT_W_DEF    = 4;
    localparam int N_REQ        = 4;

    // One-hot grant vector for a requester index.
    function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotate-priority encoder: first active request after index 'last', wrapping mod 4.
// Latency: combinational.
// Backpressure: none; 'found' low means no requester is active.
module rr_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic [1:0]       idx,
    output logic             found
);

    // Scan last+1 .. last+4 so that 'last' itself is the lowest priority.
    always_comb begin
        idx   = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[2'(last + 2'(k))]) begin
                idx   = 2'(last + 2'(k));
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a shared 4:1 single-bit channel with bounded burst length.
// Latency: grant registered one cycle after request; m is combinational from registered sel/busy.
// Backpressure: a grant is held until req[sel] drops or HOLD_MAX cycles elapse, then rotates.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       sel,
    output logic             busy,
    output logic             m
);

    state_t             r_state, w_state;
    logic [N_REQ-1:0]   r_grant, w_grant;
    logic [1:0]         r_sel, w_sel;
    logic               r_busy, w_busy;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [1:0]         r_last, w_last;

    logic [1:0]         w_pick_last;
    logic [1:0]         w_pick_idx;
    logic               w_pick_found;
    logic               w_release;

    // While a grant is active the pick must already treat the current owner as
    // lowest priority, so that a release hands over in the same edge.
    assign w_pick_last = (r_state == ST_GRANT) ? r_sel : r_last;

    rr_pick u_pick (
        .req   (req),
        .last  (w_pick_last),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign w_release = !req[r_sel] || (r_cnt == CNT_W'(HOLD_MAX));

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_sel   = r_sel;
        w_busy  = r_busy;
        w_cnt   = r_cnt;
        w_last  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state = ST_GRANT;
                    w_grant = onehot4(w_pick_idx);
                    w_sel   = w_pick_idx;
                    w_busy  = 1'b1;
                    w_cnt   = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (!w_release) begin
                    w_cnt = r_cnt + CNT_W'(1);
                end else begin
                    w_last = r_sel;
                    if (w_pick_found) begin
                        // Hand over (or re-grant the sole requester) with no idle gap.
                        w_grant = onehot4(w_pick_idx);
                        w_sel   = w_pick_idx;
                        w_cnt   = CNT_W'(1);
                    end else begin
                        // sel keeps its last value so the mux input stays stable.
                        w_state = ST_IDLE;
                        w_grant = '0;
                        w_busy  = 1'b0;
                        w_cnt   = '0;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the channel without waiting for a clock.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_sel   <= w_sel;
            r_busy  <= w_busy;
            r_cnt   <= w_cnt;
            r_last  <= w_last;
        end
    end

    assign grant = r_grant;
    assign sel   = r_sel;
    assign busy  = r_busy;
    assign m     = r_busy ? data[r_sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (HOLD_MAX=8 and HOLD_MAX=1 instances).
// Latency: expectations are tagged with the clock edge after which they must hold.
// Backpressure: n/a; the monitor drains the expectation queue every cycle.
module tb_rr_mux_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn;
    logic [3:0] req0, data0, req1, data1;
    logic [3:0] grant0, grant1;
    logic [1:0] sel0, sel1;
    logic       busy0, busy1, m0, m1;

    rr_mux_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut0 (
        .clock(clock), .resetn(resetn), .req(req0), .data(data0),
        .grant(grant0), .sel(sel0), .busy(busy0), .m(m0)
    );

    rr_mux_arbiter #(.HOLD_MAX(1), .CNT_W(4)) dut1 (
        .clock(clock), .resetn(resetn), .req(req1), .data(data1),
        .grant(grant1), .sel(sel1), .busy(busy1), .m(m1)
    );

    typedef struct {
        int         tag;
        int         dut;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       m;
        int         cnt;   // -1 = not checked
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one vector before the next edge and queue what must be seen after it.
    task automatic step(input int d, input logic [3:0] rq, input logic [3:0] dt,
                        input logic [3:0] eg, input logic [1:0] es, input logic eb,
                        input logic em, input int ec, input string nm);
        @(negedge clock);
        if (d == 0) begin
            req0  = rq;
            data0 = dt;
        end else begin
            req1  = rq;
            data1 = dt;
        end
        exp_q.push_back('{cyc + 1, d, eg, es, eb, em, ec});
        name_q.push_back(nm);
    endtask

    // Monitor: after each edge, compare every expectation due at this edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clock);
            #1;
            while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.tag < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s: sample missed, due cycle %0d now %0d", nm, e.tag, cyc);
                end else if (e.dut == 0) begin
                    chk({nm, ".grant"}, int'(grant0), int'(e.grant));
                    chk({nm, ".sel"},   int'(sel0),   int'(e.sel));
                    chk({nm, ".busy"},  int'(busy0),  int'(e.busy));
                    chk({nm, ".m"},     int'(m0),     int'(e.m));
                    if (e.cnt >= 0) chk({nm, ".cnt"}, int'(dut0.r_cnt), e.cnt);
                end else begin
                    chk({nm, ".grant"}, int'(grant1), int'(e.grant));
                    chk({nm, ".sel"},   int'(sel1),   int'(e.sel));
                    chk({nm, ".busy"},  int'(busy1),  int'(e.busy));
                    chk({nm, ".m"},     int'(m1),     int'(e.m));
                    if (e.cnt >= 0) chk({nm, ".cnt"}, int'(dut1.r_cnt), e.cnt);
                end
            end
        end
    end

    initial begin
        int idx;
        resetn = 1'b0;
        req0 = 4'b0000; data0 = 4'b0000;
        req1 = 4'b0000; data1 = 4'b0000;
        repeat (2) @(negedge clock);
        chk("rst.grant", int'(grant0), 0);
        chk("rst.sel",   int'(sel0),   0);
        chk("rst.busy",  int'(busy0),  0);
        chk("rst.m",     int'(m0),     0);
        resetn = 1'b1;

        // Idle with no requests.
        for (int k = 0; k < 5; k++)
            step(0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, -1, "idle");

        // Single request on 2, then release to idle (sel holds).
        step(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1, "req2");
        step(0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0, -1, "drop2");

        // Grant 0 (last=2), then asynchronous reset mid-grant.
        step(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1, 1, "pre_rst");
        @(negedge clock);
        #2;
        resetn = 1'b0;
        req0   = 4'b0000;
        #1;
        chk("arst.grant", int'(grant0), 0);
        chk("arst.sel",   int'(sel0),   0);
        chk("arst.busy",  int'(busy0),  0);
        chk("arst.m",     int'(m0),     0);
        chk("arst.cnt",   int'(dut0.r_cnt), 0);
        @(negedge clock);
        resetn = 1'b1;

        // All four requesting: 8-cycle bursts rotating 0,1,2,3,0 with no gaps.
        for (int k = 0; k < 40; k++) begin
            idx = (k / 8) % 4;
            step(0, 4'b1111, 4'b0101, 4'b0001 << idx, 2'(idx), 1'b1,
                 (idx % 2) == 0, (k % 8) + 1, "rotate");
        end
        step(0, 4'b0000, 4'b0101, 4'b0000, 2'd0, 1'b0, 1'b0, -1, "rot_end");

        // Sole requester 1: re-granted on timeout, never drops busy.
        for (int k = 0; k < 20; k++)
            step(0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, (k % 8) + 1, "solo1");
        step(0, 4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b0, 1'b0, -1, "solo_end");

        // Handover to the newly raised 2 ahead of 3, no idle cycle.
        step(0, 4'b0001, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0, 1, "own0");
        step(0, 4'b1001, 4'b0100, 4'b0001, 2'd0, 1'b1, 1'b0, 2, "own0_req3");
        step(0, 4'b1100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 1, "handover2");
        step(0, 4'b0110, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1, 2, "others_toggle");
        step(0, 4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0, -1, "hand_end");

        // HOLD_MAX=1: strict alternation between 1 and 3.
        for (int k = 0; k < 8; k++) begin
            if ((k % 2) == 0)
                step(1, 4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1, 1, "hm1_g1");
            else
                step(1, 4'b1010, 4'b0010, 4'b1000, 2'd3, 1'b1, 1'b0, 1, "hm1_g3");
        end
        step(1, 4'b0000, 4'b0010, 4'b0000, 2'd3, 1'b0, 1'b0, -1, "hm1_end");

        repeat (3) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
